// File: rtl/operand_entry_fsm_pkg.sv
// rtl/operand_entry_fsm_pkg.sv - shared state encoding and debounce default
// Purpose: state enumeration for the operand entry FSM and the default
//          debounce length (10 ms at 100 MHz).
// Ports:   none (package).
package operand_entry_fsm_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'b00,
    S_LOAD_B = 2'b01,
    S_READY  = 2'b10
  } state_e;

endpackage

// File: rtl/operand_entry_fsm_button_debouncer.sv
// rtl/operand_entry_fsm_button_debouncer.sv - button synchronizer, debouncer and press pulse
// Purpose: two-flop synchronizer, stability counter and one-cycle rising-edge
//          pulse for a bouncing active-high button.
// Ports:   clk   - system clock
//          rst   - asynchronous active-high reset
//          btn   - raw button level (asynchronous to clk)
//          pulse - one-cycle pulse per accepted press
module button_debouncer
  import operand_entry_fsm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [1:0]       valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             prev_q;
  logic             armed_q;
  logic             pulse_q;

  // valid_q marks when the synchronizer holds a real sample rather than its
  // reset zeros. armed_q is only set once a genuine low is observed, so a
  // button held through reset cannot fire until released and pressed again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      valid_q <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      valid_q <= {valid_q[0], 1'b1};

      // Any cycle agreeing with the accepted level restarts the count.
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (valid_q[1] && !sync_q[1] && !level_q) begin
        armed_q <= 1'b1;
      end

      prev_q  <= level_q;
      pulse_q <= level_q & ~prev_q & armed_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/operand_entry_fsm.sv
// rtl/operand_entry_fsm.sv - operand A/B and add/sub mode entry controller
// Purpose: captures two 8-bit operands from switches on debounced enter
//          presses, toggles mode on debounced mode presses and flags each
//          complete operation with a one-cycle op_valid.
// Ports:   clk, rst             - clock, asynchronous active-high reset
//          sw[7:0]              - raw operand switches
//          btn_enter, btn_mode  - raw bouncing buttons
//          a[7:0], b[7:0], mode - registered operation for the adder/subtractor
//          op_valid             - one-cycle new-operation strobe
//          state_out[1:0]       - current FSM state for LEDs
module operand_entry_fsm
  import operand_entry_fsm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       btn_enter,
  input  logic       btn_mode,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic       mode,
  output logic       op_valid,
  output logic [1:0] state_out
);

  logic [7:0] sw_meta_q;
  logic [7:0] sw_sync_q;
  logic       enter_p;
  logic       mode_p;

  state_e     state_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       mode_q;
  logic       op_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q <= 8'h00;
      sw_sync_q <= 8'h00;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_enter),
    .pulse (enter_p)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_mode),
    .pulse (mode_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOAD_A;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      mode_q     <= 1'b0;
      op_valid_q <= 1'b0;
    end else begin
      op_valid_q <= 1'b0;
      if (mode_p) begin
        mode_q <= ~mode_q;
      end
      case (state_q)
        S_LOAD_A: begin
          if (enter_p) begin
            a_q     <= sw_sync_q;
            state_q <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (enter_p) begin
            b_q        <= sw_sync_q;
            state_q    <= S_READY;
            op_valid_q <= 1'b1;
          end
        end
        S_READY: begin
          // Leaving READY abandons the operation, so a coincident mode
          // toggle does not announce a new one.
          if (enter_p) begin
            state_q <= S_LOAD_A;
          end else if (mode_p) begin
            op_valid_q <= 1'b1;
          end
        end
        default: state_q <= S_LOAD_A;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign mode      = mode_q;
  assign op_valid  = op_valid_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// tb/tb_operand_entry_fsm.sv - self-checking bench for operand_entry_fsm
module tb_operand_entry_fsm;
  import operand_entry_fsm_pkg::*;

  localparam int DB = 4;
  localparam int LAT = 2 + DB + 1 + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       btn_enter;
  logic       btn_mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       mode;
  logic       op_valid;
  logic [1:0] state_out;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: operation registers and a plain integer state 0/1/2.
  int m_a, m_b, m_mode, m_st;
  int last_lat;

  always #5 clk = ~clk;

  operand_entry_fsm #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_enter (btn_enter),
    .btn_mode  (btn_mode),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .op_valid  (op_valid),
    .state_out (state_out)
  );

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_mode = 0; m_st = 0;
  endtask

  task automatic model_step(input bit e, input bit m, input int swv, output int ov);
    ov = 0;
    if (e && m_st == 1) ov = 1;
    if (m && !e && m_st == 2) ov = 1;
    if (m) m_mode = 1 - m_mode;
    if (e) begin
      if (m_st == 0) begin m_a = swv; m_st = 1; end
      else if (m_st == 1) begin m_b = swv; m_st = 2; end
      else m_st = 0;
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".a"}, int'(a), m_a);
    check({tag, ".b"}, int'(b), m_b);
    check({tag, ".mode"}, int'(mode), m_mode);
    check({tag, ".state"}, int'(state_out), m_st);
  endtask

  task automatic idle(input int n, inout int pulses);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (op_valid === 1'b1) pulses++;
    end
  endtask

  task automatic press(input bit e, input bit m, input int swv, input string tag);
    int ov_exp;
    int pulses;
    pulses = 0;
    last_lat = 0;
    sw = swv[7:0];
    repeat (3) @(negedge clk);
    model_step(e, m, swv, ov_exp);
    btn_enter = e;
    btn_mode = m;
    for (int i = 1; i <= DB + 12; i++) begin
      @(negedge clk);
      if (op_valid === 1'b1) begin
        pulses++;
        if (last_lat == 0) last_lat = i;
        check({tag, ".ov_a"}, int'(a), m_a);
        check({tag, ".ov_b"}, int'(b), m_b);
        check({tag, ".ov_mode"}, int'(mode), m_mode);
      end
    end
    btn_enter = 1'b0;
    btn_mode = 1'b0;
    idle(DB + 12, pulses);
    check({tag, ".pulses"}, pulses, ov_exp);
    check_regs(tag);
  endtask

  initial begin
    int pulses;
    int ov_exp;
    int choice;
    rst = 1'b1;
    sw = 8'h00;
    btn_enter = 1'b0;
    btn_mode = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.op_valid", int'(op_valid), 0);
    check_regs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Two operands, then a mode change in READY
    press(1'b1, 1'b0, 8'h25, "load_a");
    press(1'b1, 1'b0, 8'h13, "load_b");
    check("latency", last_lat, LAT);
    press(1'b0, 1'b1, 8'h00, "mode_ready");
    press(1'b1, 1'b0, 8'h00, "ready_exit");

    // Bouncing enter: 2-cycle glitches must not be accepted
    pulses = 0;
    sw = 8'h3C;
    repeat (3) @(negedge clk);
    model_step(1'b1, 1'b0, 8'h3C, ov_exp);
    for (int k = 0; k < 4; k++) begin
      btn_enter = (k % 2 == 0);
      idle(2, pulses);
    end
    btn_enter = 1'b1;
    idle(20, pulses);
    btn_enter = 1'b0;
    idle(DB + 12, pulses);
    check("bounce.pulses", pulses, ov_exp);
    check_regs("bounce");

    // Coincident enter + mode in LOAD_B
    press(1'b1, 1'b1, 8'hFF, "coincide_b");
    press(1'b1, 1'b1, 8'h00, "coincide_ready");

    // Reset in LOAD_B discards partial operand
    press(1'b1, 1'b0, 8'h80, "pre_rst");
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_mid.op_valid", int'(op_valid), 0);
    check_regs("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    idle(20, pulses);
    check("rst_mid.pulses", pulses, 0);
    check_regs("rst_after");

    // Button held through reset must not fire
    btn_enter = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    idle(30, pulses);
    check("held.pulses", pulses, 0);
    check_regs("held");
    btn_enter = 1'b0;
    idle(DB + 12, pulses);
    press(1'b1, 1'b0, 8'h5A, "after_held");

    // Illegal state recovery
    force dut.state_q = state_e'(2'b11);
    #1;
    check("illegal.forced", int'(state_out), 3);
    release dut.state_q;
    @(negedge clk);
    m_st = 0;
    check("illegal.op_valid", int'(op_valid), 0);
    check_regs("illegal");

    // Randomized operations against the model
    for (int n = 0; n < 24; n++) begin
      choice = $urandom_range(0, 3);
      case (choice)
        0, 1: press(1'b1, 1'b0, $urandom_range(0, 255), "rnd_enter");
        2:    press(1'b0, 1'b1, $urandom_range(0, 255), "rnd_mode");
        default: press(1'b1, 1'b1, $urandom_range(0, 255), "rnd_both");
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/operand_entry_fsm.md
OPERAND_ENTRY_FSM -- requirements
Module: operand_entry_fsm

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 1_000_000, the number of consecutive stable cycles required before a button level change is accepted (10 ms at 100 MHz).
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-003 clk  input  1  system clock, rising-edge active.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 sw  input  8  raw operand switches, asynchronous to clk.
REQ-006 btn_enter  input  1  raw enter button, active-high, bouncing.
REQ-007 btn_mode  input  1  raw mode button, active-high, bouncing.
REQ-008 a  output  8  registered operand A for the downstream adder/subtractor.
REQ-009 b  output  8  registered operand B.
REQ-010 mode  output  1  registered operation select: 0 = add, 1 = subtract.
REQ-011 op_valid  output  1  single-cycle pulse; a, b and mode are a new complete operation.
REQ-012 state_out  output  2  current FSM state, for LED display.

Function
REQ-013 The block SHALL pass sw, btn_enter and btn_mode through two-flop synchronizers before any use.
REQ-014 Each synchronized button SHALL be debounced; the debounced level changes only after the input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any matching cycle clears the counter.
REQ-015 A rising edge of a debounced level SHALL produce exactly one one-cycle pulse: enter_p or mode_p. A held button SHALL produce no further pulses.
REQ-016 The FSM states SHALL be S_LOAD_A = 2'b00, S_LOAD_B = 2'b01 and S_READY = 2'b10. 2'b11 is illegal and SHALL recover to S_LOAD_A on the next cycle. state_out SHALL equal the state register.
REQ-017 In S_LOAD_A, on enter_p, the block SHALL register a from synchronized sw and go to S_LOAD_B.
REQ-018 In S_LOAD_B, on enter_p, the block SHALL register b from synchronized sw and go to S_READY.
REQ-019 In S_READY, on enter_p, the block SHALL go to S_LOAD_A. a and b SHALL hold their values until overwritten.
REQ-020 mode_p SHALL toggle mode in every state.
REQ-021 op_valid SHALL pulse for one cycle, on the cycle after either: (a) enter_p in S_LOAD_B, or (b) mode_p in S_READY.
REQ-022 If enter_p and mode_p occur in the same cycle in S_LOAD_B, the block SHALL capture b, toggle mode and produce exactly one op_valid pulse.
REQ-023 If enter_p and mode_p occur in the same cycle in S_READY, the block SHALL go to S_LOAD_A, toggle mode and produce no op_valid.
REQ-024 a, b and mode SHALL be stable whenever op_valid is high and until the next capture or toggle.
REQ-025 Latency from a clean raw button edge to op_valid SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) + 1 (register) cycles.
REQ-026 Operand values SHALL be unsigned 8-bit with no transformation; the block performs no arithmetic.

Reset
REQ-027 While rst is high, the block SHALL hold: a = 0, b = 0, mode = 0, op_valid = 0, state_out = S_LOAD_A, debounced levels = 0, debounce counters = 0, synchronizers = 0.
REQ-028 Reset asserted mid-entry SHALL discard any partial operands. After release, no pulse SHALL be generated for a button already held until it is released and pressed again.

Structure
REQ-029 A shared package SHALL hold the state enumeration and the DEBOUNCE_CYCLES default constant.
REQ-030 Debouncing SHALL be a sub-module, button_debouncer (sync + counter + edge pulse), instantiated twice.

Verification (DEBOUNCE_CYCLES = 4)
REQ-031 Scenario: sw = 0x25, press enter; sw = 0x13, press enter -> a = 0x25, b = 0x13, state_out = 10, one op_valid pulse, mode = 0.
REQ-032 Scenario: in S_READY, press mode -> mode = 1, one op_valid pulse, a and b unchanged.
REQ-033 Scenario: enter bounces 1-0-1-0 with 2-cycle glitches, then held 20 cycles -> exactly one capture, no glitch capture.
REQ-034 Scenario: enter and mode pulses coincide in S_LOAD_B with sw = 0xFF -> b = 0xFF, mode toggled, exactly one op_valid.
REQ-035 Scenario: rst pulsed in S_LOAD_B with a = 0x80 -> a = 0, state_out = 00, no op_valid.
REQ-036 Scenario: force state register to 2'b11 -> S_LOAD_A on the next cycle, op_valid = 0.
